tdc_multi_controller: RTL and testbench
=======================================

// Module: tdc_multi_controller
// PURPOSE
//  Parametrised multi-channel time-to-digital measurement controller; next generation of the
//  single-shot start/clear/running/ready counter controller. One start pulse clears the delay
//  line, runs a shared coarse counter and latches the count at each channel's first stop event.
//  Supports timeout, per-channel hit flags and continuous re-arm. Sits between the TDC analog
//  front end (clear/stop) and the readout logic (result/ready).
// PARAMETERS
//  N_CH          2    number of stop channels (>=1)
//  CNT_W         8    coarse counter / result width in bits (>=2)
//  CLEAR_CYCLES  2    cycles clear is held high before counting (>=1)
//  MAX_COUNT     200  timeout count value; must satisfy MAX_COUNT <= 2**CNT_W-2
// PORTS
//  clk        in   1            system clock, all logic on rising edge
//  rst        in   1            synchronous, active-high reset
//  start      in   1            begin measurement (level sampled per cycle)
//  mode_cont  in   1            0 single-shot, 1 continuous; sampled when start accepted
//  stop       in   N_CH         per-channel stop event, level sampled per cycle
//  clear      out  1            front-end clear strobe
//  running    out  1            counting window active
//  ready      out  1            results valid
//  timeout    out  1            last measurement ended on MAX_COUNT
//  hit        out  N_CH         channel i captured a stop in last measurement
//  count      out  CNT_W        live coarse counter
//  result     out  N_CH*CNT_W   channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset: state IDLE; clear, running, ready, timeout, hit, count, result all 0; mode reg 0.
//  - States: IDLE -> CLEAR -> RUN -> DONE. rst=1 at any edge forces IDLE next cycle, incl. mid-run.
//  - Start acceptance:
//      IDLE/DONE + start=1 -> CLEAR next cycle; latch mode_cont; ready, timeout, hit -> 0.
//      start while in CLEAR/RUN is ignored.
//  - CLEAR: clear=1 for exactly CLEAR_CYCLES cycles; count held 0; stop ignored.
//  - Latency: start sampled at edge k ->
//      clear=1 during cycles k+1..k+CLEAR_CYCLES;
//      running=1 from cycle k+CLEAR_CYCLES+1, with count=0 in the first RUN cycle.
//  - RUN: count += 1 per cycle. Channel i with stop[i]=1 and hit[i]=0 latches the current count
//    into result[i] and sets hit[i]. Later stops on that channel are ignored.
//  - RUN exit, to DONE next cycle, on the first of:
//      (a) all hit bits set, including those set this cycle;
//      (b) count == MAX_COUNT -> timeout=1, unhit results forced to all-ones ('1, TDC_NO_HIT).
//  - Stop coinciding with count==MAX_COUNT is captured as MAX_COUNT. hit then wins for that
//    channel; timeout=1 only if some channel remains unhit.
//  - count never wraps: MAX_COUNT <= 2**CNT_W-2, so all-ones is never a valid time.
//  - DONE: running=0, ready=1; result/hit/timeout stable.
//      single mode: stay until start.
//      continuous mode: exactly one DONE cycle, then CLEAR automatically.
//  - Continuous mode exits: rst, or mode_cont=0 sampled in DONE -> stay DONE (single-shot hold).
// STRUCTURE
//  - tdc_pkg: tdc_state_e {IDLE,CLEAR,RUN,DONE} and TDC_NO_HIT helper function (all-ones of CNT_W).
//  - Sub-module tdc_capture_ch: per-channel hit/result register with arm, stop, force_nohit
//    inputs; instantiated N_CH times via generate.
//  - Top holds the FSM, the clear-cycle counter and the coarse counter.
// TESTING
//  1. rst 1 cycle, then start pulse -> clear high exactly 2 cycles, running next, count 0,1,2...
//  2. N_CH=2, stop[0] at count 5, stop[1] at count 9 -> result {9,5}, hit=2'b11, ready next cycle,
//     timeout=0.
//  3. stop[1] never asserted, MAX_COUNT=200 -> timeout=1, result[1]=8'hFF, hit=2'b01, ready at
//     count 200.
//  4. Both stops asserted in same cycle at count 3, plus extra stop[0] pulses -> both results 3,
//     extras ignored.
//  5. mode_cont=1 with stops at 4 and 6 -> ready pulses 1 cycle, clear re-asserts automatically;
//     three back-to-back identical results.
//  6. rst asserted mid-RUN at count 50 -> next cycle all outputs 0, IDLE; start mid-RUN ignored.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multi-channel TDC controller.
// The state encoding is fixed so that the controller can mirror it in plain localparams.
package tdc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } tdc_state_e;

   localparam int unsigned TDC_MAX_W = 64;

   // All-ones marker for a channel with no stop; callers truncate it to their result width.
   function automatic logic [TDC_MAX_W-1:0] TDC_NO_HIT();
      return '1;
   endfunction

endpackage

// File: rtl/tdc_capture_ch.sv
// Per-channel stop capture: latches the first stop count of a measurement and sets hit.
// On a timeout, a channel that was never hit reports the all-ones no-hit marker.
module tdc_capture_ch
   import tdc_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             arm,
   input  logic             stop,
   input  logic             force_nohit,
   input  logic [CNT_W-1:0] count,
   output logic             hit,
   output logic [CNT_W-1:0] result
);

   localparam logic [CNT_W-1:0] NO_HIT = CNT_W'(TDC_NO_HIT());

   always_ff @(posedge clk) begin
      if (rst) begin
         hit    <= 1'b0;
         result <= '0;
      end else if (clr) begin
         hit <= 1'b0;
      end else if (arm && stop && !hit) begin
         result <= count;
         hit    <= 1'b1;
      end else if (force_nohit && !hit) begin
         result <= NO_HIT;
      end
   end

endmodule

// File: rtl/tdc_multi_controller.sv
// Multi-channel time-to-digital controller: clear phase, shared coarse counter,
// per-channel first-stop capture, timeout, and optional continuous re-arm.
module tdc_multi_controller
   import tdc_pkg::*;
#(
   parameter int unsigned N_CH         = 2,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned CLEAR_CYCLES = 2,
   parameter int unsigned MAX_COUNT    = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode_cont,
   input  logic [N_CH-1:0]       stop,
   output logic                  clear,
   output logic                  running,
   output logic                  ready,
   output logic                  timeout,
   output logic [N_CH-1:0]       hit,
   output logic [CNT_W-1:0]      count,
   output logic [N_CH*CNT_W-1:0] result
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_CLEAR = CLEAR;
   localparam logic [1:0] ST_RUN   = RUN;
   localparam logic [1:0] ST_DONE  = DONE;

   localparam int unsigned      CCW      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam logic [CCW-1:0]   CLR_LAST = CCW'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

   logic [1:0]       state;
   logic [CCW-1:0]   clr_cnt;
   logic [CNT_W-1:0] cnt;
   logic             mode_reg;
   logic             timeout_r;
   logic [N_CH-1:0]  hit_w;

   logic accept, restart, launch, arm, all_hit, at_max, force_nohit;

   always_comb begin
      accept      = ((state == ST_IDLE) || (state == ST_DONE)) && start;
      restart     = (state == ST_DONE) && !start && mode_reg && mode_cont;
      launch      = accept || restart;
      arm         = (state == ST_RUN);
      // Stops arriving this cycle count towards completion, so the last hit ends RUN at once.
      all_hit     = &(hit_w | stop);
      at_max      = (cnt == CNT_MAX);
      force_nohit = arm && at_max && !all_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         clr_cnt   <= '0;
         cnt       <= '0;
         mode_reg  <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (launch) begin
                  state     <= ST_CLEAR;
                  clr_cnt   <= '0;
                  cnt       <= '0;
                  timeout_r <= 1'b0;
                  if (accept)
                     mode_reg <= mode_cont;
               end else if (mode_reg) begin
                  // Continuous mode dropped while in DONE: hold results as a single shot.
                  mode_reg <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == CLR_LAST)
                  state <= ST_RUN;
               else
                  clr_cnt <= clr_cnt + 1'b1;
            end
            ST_RUN: begin
               if (all_hit) begin
                  state <= ST_DONE;
               end else if (at_max) begin
                  state     <= ST_DONE;
                  timeout_r <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tdc_capture_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .clr        (launch),
         .arm        (arm),
         .stop       (stop[i]),
         .force_nohit(force_nohit),
         .count      (cnt),
         .hit        (hit_w[i]),
         .result     (result[i*CNT_W +: CNT_W])
      );
   end

   assign clear   = (state == ST_CLEAR);
   assign running = (state == ST_RUN);
   assign ready   = (state == ST_DONE);
   assign timeout = timeout_r;
   assign hit     = hit_w;
   assign count   = cnt;

endmodule

// File: tb/tb_tdc_multi_controller.sv
// Directed self-checking bench for tdc_multi_controller (N_CH=2, CNT_W=8, CLEAR_CYCLES=2, MAX_COUNT=200).
module tb_tdc_multi_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mode_cont = 1'b0;
   logic [1:0]  stop = 2'b00;
   logic        clear, running, ready, timeout;
   logic [1:0]  hit;
   logic [7:0]  count;
   logic [15:0] result;

   int unsigned passed = 0;
   int unsigned total  = 0;

   tdc_multi_controller #(
      .N_CH        (2),
      .CNT_W       (8),
      .CLEAR_CYCLES(2),
      .MAX_COUNT   (200)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode_cont(mode_cont),
      .stop     (stop),
      .clear    (clear),
      .running  (running),
      .ready    (ready),
      .timeout  (timeout),
      .hit      (hit),
      .count    (count),
      .result   (result)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset state, clear width, counting start
      rst = 1'b1;
      step();
      check("rst_clear",   32'(clear),   0);
      check("rst_running", 32'(running), 0);
      check("rst_ready",   32'(ready),   0);
      check("rst_timeout", 32'(timeout), 0);
      check("rst_hit",     32'(hit),     0);
      check("rst_count",   32'(count),   0);
      check("rst_result",  32'(result),  0);
      rst = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("t1_clear1",   32'(clear),   1);
      check("t1_run1",     32'(running), 0);
      step();
      check("t1_clear2",   32'(clear),   1);
      step();
      check("t1_clear3",   32'(clear),   0);
      check("t1_running",  32'(running), 1);
      check("t1_count0",   32'(count),   0);
      step();
      check("t1_count1",   32'(count),   1);
      step();
      check("t1_count2",   32'(count),   2);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // 2: stops at 5 and 9
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      repeat (5) step();
      check("t2_count5",   32'(count),   5);
      stop = 2'b01;
      step();
      stop = 2'b00;
      check("t2_hit0",     32'(hit),     32'h1);
      check("t2_ready_early", 32'(ready), 0);
      repeat (3) step();
      check("t2_count9",   32'(count),   9);
      stop = 2'b10;
      step();
      stop = 2'b00;
      check("t2_ready",    32'(ready),   1);
      check("t2_running",  32'(running), 0);
      check("t2_result",   32'(result),  32'h0905);
      check("t2_hit",      32'(hit),     32'h3);
      check("t2_timeout",  32'(timeout), 0);
      step();
      check("t2_ready_hold", 32'(ready), 1);

      // 3: channel 1 never stops -> timeout; repeated stop[0] ignored
      start = 1'b1;
      step();
      start = 1'b0;
      check("t3_ready_cleared", 32'(ready), 0);
      check("t3_hit_cleared",   32'(hit),   0);
      step();
      step();
      repeat (2) step();
      stop = 2'b01;
      step();
      stop = 2'b00;
      repeat (7) step();
      check("t3_count10",  32'(count),   10);
      stop = 2'b01;
      step();
      stop = 2'b00;
      repeat (189) step();
      check("t3_count200", 32'(count),   200);
      check("t3_running",  32'(running), 1);
      step();
      check("t3_ready",    32'(ready),   1);
      check("t3_timeout",  32'(timeout), 1);
      check("t3_result",   32'(result),  32'hFF02);
      check("t3_hit",      32'(hit),     32'h1);
      check("t3_count_hold", 32'(count), 200);

      // 4: simultaneous stops at 3, extra stop[0] pulses afterwards
      start = 1'b1;
      step();
      start = 1'b0;
      check("t4_timeout_cleared", 32'(timeout), 0);
      step();
      step();
      repeat (3) step();
      stop = 2'b11;
      step();
      stop = 2'b01;
      check("t4_ready",    32'(ready),   1);
      step();
      stop = 2'b00;
      step();
      stop = 2'b01;
      step();
      stop = 2'b00;
      check("t4_result",   32'(result),  32'h0303);
      check("t4_hit",      32'(hit),     32'h3);
      check("t4_timeout",  32'(timeout), 0);

      // 5: continuous mode, three back-to-back measurements, last one exits
      start = 1'b1;
      mode_cont = 1'b1;
      step();
      start = 1'b0;
      for (int it = 0; it < 3; it++) begin
         check("t5_clear_a", 32'(clear), 1);
         step();
         check("t5_clear_b", 32'(clear), 1);
         step();
         check("t5_count0",  32'(count), 0);
         repeat (4) step();
         stop = 2'b01;
         step();
         stop = 2'b00;
         step();
         stop = 2'b10;
         if (it == 2) mode_cont = 1'b0;
         step();
         stop = 2'b00;
         check("t5_ready",   32'(ready),  1);
         check("t5_result",  32'(result), 32'h0604);
         check("t5_hit",     32'(hit),    32'h3);
         step();
         if (it < 2) begin
            check("t5_ready_pulse", 32'(ready), 0);
            check("t5_rearm",       32'(clear), 1);
         end else begin
            check("t5_hold_ready",  32'(ready), 1);
            check("t5_hold_clear",  32'(clear), 0);
         end
      end

      // 6: start ignored mid-run, reset at count 50
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      repeat (20) step();
      start = 1'b1;
      step();
      start = 1'b0;
      check("t6_ignore_run",   32'(running), 1);
      check("t6_ignore_clear", 32'(clear),   0);
      check("t6_count21",      32'(count),   21);
      repeat (29) step();
      check("t6_count50",      32'(count),   50);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_clear",   32'(clear),   0);
      check("t6_running", 32'(running), 0);
      check("t6_ready",   32'(ready),   0);
      check("t6_timeout", 32'(timeout), 0);
      check("t6_hit",     32'(hit),     0);
      check("t6_count",   32'(count),   0);
      check("t6_result",  32'(result),  0);
      step();
      check("t6_idle_running", 32'(running), 0);
      check("t6_idle_clear",   32'(clear),   0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
